// File: rtl/gshare_bpred_pkg.sv
// Shared configuration for the gshare branch predictor: default widths,
// PC bit-range helpers, the PHT counter reset value and the history select.
package gshare_bpred_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_GHR_WIDTH  = 8;
    localparam int DEF_CTR_WIDTH  = 2;
    localparam int DEF_BTB_SETS   = 64;
    localparam int DEF_BTB_WAYS   = 2;

    // Instructions are word aligned, so PC bits [1:0] never take part in indexing.
    localparam int PC_IDX_LSB = 2;

    // Most significant PC bit of a field of the given width that starts at PC_IDX_LSB.
    function automatic int idxMsb(input int fieldBits);
        return fieldBits + PC_IDX_LSB - 1;
    endfunction

    // Tag bits left over once the set index and the alignment bits are removed.
    function automatic int tagWidth(input int addrWidth, input int setBits);
        return addrWidth - setBits - PC_IDX_LSB;
    endfunction

    // Counters reset to the weakly not-taken value, just below the MSB threshold.
    function automatic int ctrResetVal(input int ctrWidth);
        return (1 << (ctrWidth - 1)) - 1;
    endfunction

    // Source of the next speculative history value.
    typedef enum logic [1:0] {
        GHR_HOLD,
        GHR_SHIFT,
        GHR_REPAIR
    } ghr_op_e;

endpackage

// File: rtl/gshare_bpred_btb.sv
// Set-associative branch target buffer (1 or 2 ways) with per-set LRU.
// Lookup is combinational; fills and target rewrites land at the next edge.
module btb_array
    import gshare_bpred_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BTB_SETS   = DEF_BTB_SETS,
    parameter int BTB_WAYS   = DEF_BTB_WAYS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] lookup_pc_i,
    output logic                  hit_o,
    output logic [ADDR_WIDTH-1:0] target_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_pc_i,
    input  logic [ADDR_WIDTH-1:0] wr_target_i
);

    localparam int SET_BITS = $clog2(BTB_SETS);
    localparam int TAG_W    = tagWidth(ADDR_WIDTH, SET_BITS);
    localparam int WAY_BITS = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;
    localparam int SET_MSB  = idxMsb(SET_BITS);

    logic [BTB_WAYS-1:0]   valid_q  [BTB_SETS];
    logic [TAG_W-1:0]      tag_q    [BTB_SETS][BTB_WAYS];
    logic [ADDR_WIDTH-1:0] target_q [BTB_SETS][BTB_WAYS];

    logic [SET_BITS-1:0] lkSet, wrSet;
    logic [TAG_W-1:0]    lkTag, wrTag;
    logic                wrHit, invFound;
    logic [WAY_BITS-1:0] wrHitWay, invWay, lruWay, fillWay;
    logic                unusedLowBits;

    assign lkSet = lookup_pc_i[SET_MSB:PC_IDX_LSB];
    assign lkTag = lookup_pc_i[ADDR_WIDTH-1:SET_MSB+1];
    assign wrSet = wr_pc_i[SET_MSB:PC_IDX_LSB];
    assign wrTag = wr_pc_i[ADDR_WIDTH-1:SET_MSB+1];
    assign unusedLowBits = ^{lookup_pc_i[PC_IDX_LSB-1:0], wr_pc_i[PC_IDX_LSB-1:0]};

    // Read side: compare every way of the fetch set against the fetch tag.
    always_comb begin
        hit_o    = 1'b0;
        target_o = '0;
        for (int w = BTB_WAYS - 1; w >= 0; w--) begin
            if (valid_q[lkSet][w] && (tag_q[lkSet][w] == lkTag)) begin
                hit_o    = 1'b1;
                target_o = target_q[lkSet][w];
            end
        end
    end

    // Write side: find a hitting way and the lowest-numbered invalid way of the update set.
    always_comb begin
        wrHit    = 1'b0;
        wrHitWay = '0;
        invFound = 1'b0;
        invWay   = '0;
        for (int w = BTB_WAYS - 1; w >= 0; w--) begin
            if (valid_q[wrSet][w] && (tag_q[wrSet][w] == wrTag)) begin
                wrHit    = 1'b1;
                wrHitWay = WAY_BITS'(w);
            end
            if (!valid_q[wrSet][w]) begin
                invFound = 1'b1;
                invWay   = WAY_BITS'(w);
            end
        end
    end

    assign fillWay = wrHit ? wrHitWay : (invFound ? invWay : lruWay);

    if (BTB_WAYS == 2) begin : g_lru
        logic [WAY_BITS-1:0] lru_q [BTB_SETS];

        // Each set remembers its LRU way; the way just written becomes MRU.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < BTB_SETS; s++) begin
                    lru_q[s] <= '0;
                end
            end else if (wr_en_i) begin
                lru_q[wrSet] <= ~fillWay;
            end
        end

        assign lruWay = lru_q[wrSet];
    end else begin : g_nolru
        assign lruWay = '0;
    end

    // Valid bits are the only BTB storage that needs clearing on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < BTB_SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (wr_en_i) begin
            valid_q[wrSet][fillWay] <= 1'b1;
        end
    end

    // Tag and target payload, meaningful only where the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wrSet][fillWay]    <= wrTag;
            target_q[wrSet][fillWay] <= wr_target_i;
        end
    end

endmodule

// File: rtl/gshare_bpred.sv
// Gshare direction predictor with speculative global history and a BTB for
// targets. Prediction is combinational from pc_i; training arrives later
// with the history snapshot that was used at prediction time.
module gshare_bpred
    import gshare_bpred_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int GHR_WIDTH  = DEF_GHR_WIDTH,
    parameter int CTR_WIDTH  = DEF_CTR_WIDTH,
    parameter int BTB_SETS   = DEF_BTB_SETS,
    parameter int BTB_WAYS   = DEF_BTB_WAYS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  lookup_en,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  predict_result,
    output logic [GHR_WIDTH-1:0]  ghr_o,
    input  logic                  predict_update,
    input  logic [ADDR_WIDTH-1:0] branch_pc,
    input  logic [ADDR_WIDTH-1:0] branch_npc,
    input  logic [GHR_WIDTH-1:0]  branch_ghr,
    input  logic                  actual_result,
    input  logic                  mispredict
);

    localparam int                   PHT_DEPTH = 1 << GHR_WIDTH;
    localparam int                   PHT_MSB   = idxMsb(GHR_WIDTH);
    localparam logic [CTR_WIDTH-1:0] CTR_RESET = CTR_WIDTH'(ctrResetVal(CTR_WIDTH));
    localparam logic [CTR_WIDTH-1:0] CTR_MAX   = '1;

    logic [GHR_WIDTH-1:0]  ghr_q, ghr_d;
    logic [CTR_WIDTH-1:0]  pht_q [PHT_DEPTH];
    logic [CTR_WIDTH-1:0]  ctr_d;
    logic [GHR_WIDTH-1:0]  lookIdx, updIdx;
    logic                  btbHit, btbWrite, predTaken;
    logic [ADDR_WIDTH-1:0] btbTarget;
    ghr_op_e               ghrOp;

    assign lookIdx  = pc_i[PHT_MSB:PC_IDX_LSB] ^ ghr_q;
    assign updIdx   = branch_pc[PHT_MSB:PC_IDX_LSB] ^ branch_ghr;
    assign btbWrite = predict_update && actual_result && !rst;

    btb_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BTB_SETS   (BTB_SETS),
        .BTB_WAYS   (BTB_WAYS)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc_i (pc_i),
        .hit_o       (btbHit),
        .target_o    (btbTarget),
        .wr_en_i     (btbWrite),
        .wr_pc_i     (branch_pc),
        .wr_target_i (branch_npc)
    );

    assign predTaken      = !rst && btbHit && pht_q[lookIdx][CTR_WIDTH-1];
    assign predict_result = predTaken;
    assign pc_o           = rst ? '0 : (predTaken ? btbTarget : pc_i + ADDR_WIDTH'(4));
    assign ghr_o          = rst ? '0 : ghr_q;

    // Next history: a mispredict repair beats the speculative shift of a lookup.
    always_comb begin
        ghrOp = GHR_HOLD;
        ghr_d = ghr_q;
        if (predict_update && mispredict) begin
            ghrOp = GHR_REPAIR;
        end else if (lookup_en) begin
            ghrOp = GHR_SHIFT;
        end
        case (ghrOp)
            GHR_REPAIR: ghr_d = {branch_ghr[GHR_WIDTH-2:0], actual_result};
            GHR_SHIFT:  ghr_d = {ghr_q[GHR_WIDTH-2:0], predTaken};
            default:    ghr_d = ghr_q;
        endcase
    end

    // Speculative global history register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // Saturating step of the counter named by the resolved branch.
    always_comb begin
        ctr_d = pht_q[updIdx];
        if (actual_result) begin
            if (pht_q[updIdx] != CTR_MAX) begin
                ctr_d = pht_q[updIdx] + 1'b1;
            end
        end else if (pht_q[updIdx] != '0) begin
            ctr_d = pht_q[updIdx] - 1'b1;
        end
    end

    // Pattern history table, trained on every resolved branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht_q[i] <= CTR_RESET;
            end
        end else if (predict_update) begin
            pht_q[updIdx] <= ctr_d;
        end
    end

endmodule

// File: tb/tb_gshare_bpred.sv
// Self-checking bench for gshare_bpred with default parameters. A reference
// model (counter array, timestamped BTB ways, history byte) predicts outputs.
module tb_gshare_bpred;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        lookup_en;
    logic [31:0] pc_o;
    logic        predict_result;
    logic [7:0]  ghr_o;
    logic        predict_update;
    logic [31:0] branch_pc;
    logic [31:0] branch_npc;
    logic [7:0]  branch_ghr;
    logic        actual_result;
    logic        mispredict;

    int checks   = 0;
    int failures = 0;

    int          mPht   [256];
    logic [7:0]  mGhr;
    bit          mVal   [64][2];
    logic [31:0] mPc    [64][2];
    logic [31:0] mTgt   [64][2];
    int          mStamp [64][2];
    int          stampCtr;

    gshare_bpred dut (
        .clk            (clk),
        .rst            (rst),
        .pc_i           (pc_i),
        .lookup_en      (lookup_en),
        .pc_o           (pc_o),
        .predict_result (predict_result),
        .ghr_o          (ghr_o),
        .predict_update (predict_update),
        .branch_pc      (branch_pc),
        .branch_npc     (branch_npc),
        .branch_ghr     (branch_ghr),
        .actual_result  (actual_result),
        .mispredict     (mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state after a reset: empty BTB, weakly not-taken counters.
    task automatic model_reset();
        for (int i = 0; i < 256; i++) mPht[i] = 1;
        for (int s = 0; s < 64; s++) begin
            for (int w = 0; w < 2; w++) begin
                mVal[s][w]   = 0;
                mPc[s][w]    = '0;
                mTgt[s][w]   = '0;
                mStamp[s][w] = 0;
            end
        end
        mGhr     = '0;
        stampCtr = 0;
    endtask

    // Expected prediction for a fetch PC from the current model state.
    task automatic model_lookup(input logic [31:0] pc, output logic taken, output logic [31:0] npc);
        int          s;
        bit          hit;
        logic [31:0] tgt;
        logic [7:0]  idx;
        s   = int'(pc[7:2]);
        hit = 0;
        tgt = '0;
        for (int w = 0; w < 2; w++) begin
            if (mVal[s][w] && (mPc[s][w][31:8] == pc[31:8])) begin
                hit = 1;
                tgt = mTgt[s][w];
            end
        end
        idx   = pc[9:2] ^ mGhr;
        taken = hit && (mPht[idx] >= 2);
        npc   = taken ? tgt : pc + 32'd4;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        logic        t;
        logic [31:0] n;
        logic [7:0]  newGhr;
        logic [7:0]  idx;
        int          s;
        int          way;
        int          oldest;
        if (rst) begin
            model_reset();
            return;
        end
        model_lookup(pc_i, t, n);
        newGhr = mGhr;
        if (lookup_en) newGhr = {mGhr[6:0], t};
        if (predict_update && mispredict) newGhr = {branch_ghr[6:0], actual_result};
        if (predict_update) begin
            idx = branch_pc[9:2] ^ branch_ghr;
            if (actual_result) begin
                if (mPht[idx] < 3) mPht[idx] = mPht[idx] + 1;
            end else if (mPht[idx] > 0) begin
                mPht[idx] = mPht[idx] - 1;
            end
            if (actual_result) begin
                s   = int'(branch_pc[7:2]);
                way = -1;
                for (int w = 0; w < 2; w++)
                    if (mVal[s][w] && (mPc[s][w][31:8] == branch_pc[31:8])) way = w;
                if (way < 0)
                    for (int w = 1; w >= 0; w--)
                        if (!mVal[s][w]) way = w;
                if (way < 0) begin
                    oldest = (mStamp[s][0] <= mStamp[s][1]) ? 0 : 1;
                    way    = oldest;
                end
                stampCtr++;
                mVal[s][way]   = 1;
                mPc[s][way]    = branch_pc;
                mTgt[s][way]   = branch_npc;
                mStamp[s][way] = stampCtr;
            end
        end
        mGhr = newGhr;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lookup_en      = 1'b0;
        predict_update = 1'b0;
        branch_pc      = '0;
        branch_npc     = '0;
        branch_ghr     = '0;
        actual_result  = 1'b0;
        mispredict     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic train(input logic [31:0] bpc, input logic [31:0] npc, input logic taken);
        idle_inputs();
        predict_update = 1'b1;
        branch_pc      = bpc;
        branch_npc     = npc;
        branch_ghr     = 8'h00;
        actual_result  = taken;
        tick();
        idle_inputs();
    endtask

    // Outputs held at zero during reset, activity ignored, clean state afterwards.
    task automatic test_reset();
        $display("[TB] test_reset");
        rst            = 1'b1;
        pc_i           = 32'h0000_1234;
        lookup_en      = 1'b1;
        predict_update = 1'b1;
        branch_pc      = 32'h0000_0100;
        branch_npc     = 32'h0000_0500;
        branch_ghr     = 8'hFF;
        actual_result  = 1'b1;
        mispredict     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (pc_o !== 32'h0 || predict_result !== 1'b0 || ghr_o !== 8'h00) begin
                failures++;
                $display("[TB] FAIL reset_outputs cycle %0d: pc_o=%h pred=%b ghr=%h, expected 0/0/0",
                         i, pc_o, predict_result, ghr_o);
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        pc_i = 32'h0000_0100;
        #2;
        checks++;
        if (pc_o !== 32'h0000_0104 || predict_result !== 1'b0 || ghr_o !== 8'h00) begin
            failures++;
            $display("[TB] FAIL post_reset_lookup: pc_o=%h pred=%b ghr=%h, expected 00000104/0/00",
                     pc_o, predict_result, ghr_o);
        end
    endtask

    // Two taken updates make 0x100 predict taken to 0x200.
    task automatic test_train();
        $display("[TB] test_train");
        train(32'h100, 32'h200, 1'b1);
        train(32'h100, 32'h200, 1'b1);
        pc_i = 32'h100;
        #2;
        checks++;
        if (pc_o !== 32'h200 || predict_result !== 1'b1) begin
            failures++;
            $display("[TB] FAIL trained_hit: pc_o=%h pred=%b, expected 00000200/1", pc_o, predict_result);
        end
    endtask

    // Counter saturates at both ends instead of wrapping.
    task automatic test_saturate();
        $display("[TB] test_saturate");
        for (int i = 0; i < 5; i++) train(32'h100, 32'h200, 1'b1);
        train(32'h100, 32'h200, 1'b0);
        pc_i = 32'h100;
        #2;
        checks++;
        if (pc_o !== 32'h200 || predict_result !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_high: pc_o=%h pred=%b, expected 00000200/1", pc_o, predict_result);
        end
        train(32'h100, 32'h200, 1'b0);
        train(32'h100, 32'h200, 1'b0);
        #2;
        checks++;
        if (pc_o !== 32'h104 || predict_result !== 1'b0) begin
            failures++;
            $display("[TB] FAIL counter_zero: pc_o=%h pred=%b, expected 00000104/0", pc_o, predict_result);
        end
        train(32'h100, 32'h200, 1'b0);
        train(32'h100, 32'h200, 1'b1);
        #2;
        checks++;
        if (pc_o !== 32'h104 || predict_result !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sat_low: pc_o=%h pred=%b, expected 00000104/0", pc_o, predict_result);
        end
    endtask

    // Three branches in set 0 evict the LRU one; a hit refreshes recency.
    task automatic test_lru();
        logic [31:0] pcs [3];
        logic [31:0] exp [3];
        logic        expT [3];
        $display("[TB] test_lru");
        do_reset();
        pc_i = 32'h100;
        #2;
        checks++;
        if (pc_o !== 32'h104 || predict_result !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_residue: pc_o=%h pred=%b, expected 00000104/0", pc_o, predict_result);
        end
        train(32'h100, 32'h1A0, 1'b1);
        train(32'h200, 32'h2A0, 1'b1);
        train(32'h300, 32'h3A0, 1'b1);
        pcs  = '{32'h100, 32'h200, 32'h300};
        exp  = '{32'h104, 32'h2A0, 32'h3A0};
        expT = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            pc_i = pcs[i];
            #2;
            checks++;
            if (pc_o !== exp[i] || predict_result !== expT[i]) begin
                failures++;
                $display("[TB] FAIL lru_evict pc=%h: pc_o=%h pred=%b, expected %h/%b",
                         pcs[i], pc_o, predict_result, exp[i], expT[i]);
            end
        end
        train(32'h200, 32'h2B0, 1'b1);
        train(32'h100, 32'h1C0, 1'b1);
        exp = '{32'h1C0, 32'h2B0, 32'h304};
        expT = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            pc_i = pcs[i];
            #2;
            checks++;
            if (pc_o !== exp[i] || predict_result !== expT[i]) begin
                failures++;
                $display("[TB] FAIL lru_refresh pc=%h: pc_o=%h pred=%b, expected %h/%b",
                         pcs[i], pc_o, predict_result, exp[i], expT[i]);
            end
        end
    endtask

    // Mispredict repair wins over a same-cycle speculative shift.
    task automatic test_ghr_repair();
        $display("[TB] test_ghr_repair");
        idle_inputs();
        pc_i           = 32'h4000;
        predict_update = 1'b1;
        mispredict     = 1'b1;
        branch_pc      = 32'h400;
        branch_npc     = 32'h480;
        branch_ghr     = 8'h07;
        actual_result  = 1'b1;
        tick();
        idle_inputs();
        #2;
        checks++;
        if (ghr_o !== 8'h0F) begin
            failures++;
            $display("[TB] FAIL ghr_setup: ghr=%h, expected 0f", ghr_o);
        end
        lookup_en      = 1'b1;
        predict_update = 1'b1;
        mispredict     = 1'b1;
        branch_pc      = 32'h400;
        branch_npc     = 32'h480;
        branch_ghr     = 8'h03;
        actual_result  = 1'b1;
        tick();
        idle_inputs();
        #2;
        checks++;
        if (ghr_o !== 8'h07) begin
            failures++;
            $display("[TB] FAIL ghr_repair_priority: ghr=%h, expected 07", ghr_o);
        end
        lookup_en = 1'b1;
        tick();
        idle_inputs();
        #2;
        checks++;
        if (ghr_o !== 8'h0E) begin
            failures++;
            $display("[TB] FAIL ghr_shift: ghr=%h, expected 0e", ghr_o);
        end
    endtask

    // An update is invisible to a lookup of the same PC until the next cycle.
    task automatic test_same_cycle();
        $display("[TB] test_same_cycle");
        do_reset();
        pc_i           = 32'h600;
        predict_update = 1'b1;
        branch_pc      = 32'h600;
        branch_npc     = 32'h700;
        branch_ghr     = 8'h00;
        actual_result  = 1'b1;
        #2;
        checks++;
        if (pc_o !== 32'h604 || predict_result !== 1'b0) begin
            failures++;
            $display("[TB] FAIL same_cycle_old: pc_o=%h pred=%b, expected 00000604/0", pc_o, predict_result);
        end
        tick();
        idle_inputs();
        #2;
        checks++;
        if (pc_o !== 32'h700 || predict_result !== 1'b1) begin
            failures++;
            $display("[TB] FAIL same_cycle_next: pc_o=%h pred=%b, expected 00000700/1", pc_o, predict_result);
        end
    endtask

    // Random mix of lookups, updates, repairs and occasional resets against the model.
    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] expPc;
        logic        expT;
        logic [7:0]  expG;
        $display("[TB] test_random");
        pool = '{32'h100, 32'h200, 32'h300, 32'h500, 32'h104, 32'h1100, 32'h2204, 32'h308};
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst            = ($urandom_range(59) == 0);
            pc_i           = pool[$urandom_range(7)];
            lookup_en      = $urandom_range(1) == 1;
            predict_update = $urandom_range(2) != 0;
            branch_pc      = pool[$urandom_range(7)];
            branch_npc     = {$urandom_range(32'hFFFF), 2'b00};
            branch_ghr     = ($urandom_range(1) == 1) ? mGhr : 8'($urandom_range(255));
            actual_result  = $urandom_range(3) != 0;
            mispredict     = $urandom_range(3) == 0;
            #2;
            if (rst) begin
                expPc = '0;
                expT  = 1'b0;
                expG  = '0;
            end else begin
                model_lookup(pc_i, expT, expPc);
                expG = mGhr;
            end
            checks++;
            if (pc_o !== expPc) begin
                failures++;
                $display("[TB] FAIL rand_pc_o cycle %0d: got %h expected %h", c, pc_o, expPc);
            end
            checks++;
            if (predict_result !== expT) begin
                failures++;
                $display("[TB] FAIL rand_pred cycle %0d: got %b expected %b", c, predict_result, expT);
            end
            checks++;
            if (ghr_o !== expG) begin
                failures++;
                $display("[TB] FAIL rand_ghr cycle %0d: got %h expected %h", c, ghr_o, expG);
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst  = 1'b1;
        pc_i = '0;
        idle_inputs();
        model_reset();
        test_reset();
        test_train();
        test_saturate();
        test_lru();
        test_ghr_repair();
        test_same_cycle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gshare_bpred.md
GSHARE_BPRED -- requirements
Module: gshare_bpred

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, instruction address width.
REQ-002 Parameter GHR_WIDTH, default 8, global history bits; also log2 of PHT depth.
REQ-003 Parameter CTR_WIDTH, default 2, saturating counter width, range 2..4.
REQ-004 Parameter BTB_SETS, default 64, power of two.
REQ-005 Parameter BTB_WAYS, default 2, legal values 1 or 2.
REQ-006 clk  in  1  system clock; one clock, all state on rising edge.
REQ-007 rst  in  1  synchronous reset, active-high.
REQ-008 pc_i  in  ADDR_WIDTH  fetch PC being predicted.
REQ-009 lookup_en  in  1  fetch consumes this cycle's prediction; advances speculative history.
REQ-010 pc_o  out  ADDR_WIDTH  predicted next PC.
REQ-011 predict_result  out  1  predicted taken.
REQ-012 ghr_o  out  GHR_WIDTH  history snapshot used for this lookup; travels with the instruction.
REQ-013 predict_update  in  1  resolved branch report valid.
REQ-014 branch_pc  in  ADDR_WIDTH  resolved branch PC.
REQ-015 branch_npc  in  ADDR_WIDTH  resolved taken target.
REQ-016 branch_ghr  in  GHR_WIDTH  ghr_o snapshot captured at prediction.
REQ-017 actual_result  in  1  branch actually taken.
REQ-018 mispredict  in  1  qualifies predict_update; history repair required.

Function
REQ-019 Lookup is combinational, zero latency: PHT index = pc_i[GHR_WIDTH+1:2] XOR ghr; BTB set = pc_i[log2(BTB_SETS)+1:2]; tag = remaining upper bits.
REQ-020 predict_result = 1 only when a valid way in the set has a matching tag and the PHT counter MSB = 1; pc_o = that way's target, else pc_i+4 (mod 2^ADDR_WIDTH), predict_result = 0.
REQ-021 ghr_o equals the current speculative ghr register.
REQ-022 lookup_en=1: ghr <= {ghr[GHR_WIDTH-2:0], predict_result} at the next edge.
REQ-023 predict_update=1 and mispredict=1: ghr <= {branch_ghr[GHR_WIDTH-2:0], actual_result}; takes priority over a same-cycle lookup_en.
REQ-024 predict_update=1: counter at index branch_pc[GHR_WIDTH+1:2] XOR branch_ghr increments on taken, decrements on not-taken; saturates at 2^CTR_WIDTH-1 and 0, no wrap.
REQ-025 Taken update, BTB hit: overwrite the target with branch_npc; mark the hit way MRU.
REQ-026 Taken update, BTB miss: fill the lowest-numbered invalid way; if none invalid, replace the LRU way; set tag, target, valid; mark the filled way MRU.
REQ-027 Not-taken update: BTB unchanged.
REQ-028 BTB_WAYS=1: no LRU state; a miss always replaces way 0.
REQ-029 Same-cycle lookup and update to the same entry: lookup returns the pre-update contents; the write is visible from the next cycle.
REQ-030 Lookups do not modify LRU state.

Reset
REQ-031 On rst=1 at an edge: all BTB valid bits 0, LRU bits 0, ghr 0, every counter 2^(CTR_WIDTH-1)-1 (weakly not-taken).
REQ-032 While rst=1: pc_o = 0, predict_result = 0, ghr_o = 0; predict_update and lookup_en ignored.
REQ-033 Reset asserted mid-operation discards all history and training with no residue.

Structure
REQ-034 The shared package/config header holds default widths, the index and tag bit-range macros, and the counter reset-value constant.
REQ-035 The BTB is one sub-module, btb_array (sets, ways, tag compare, LRU, fill); the PHT and GHR stay in gshare_bpred.

Verification
REQ-036 Reset, then pc_i=0x100 -> pc_o=0x104, predict_result=0, ghr_o=0x00.
REQ-037 Two taken updates from 0x100 (npc 0x200, branch_ghr=0), then lookup with ghr=0 -> pc_o=0x200, predict_result=1.
REQ-038 Counter at 3, five more taken updates, then one not-taken -> counter 2, prediction still taken; counter at 0, a not-taken update leaves it at 0.
REQ-039 Three taken branches 0x100, 0x200, 0x300 sharing BTB set 0 (64 sets, 2 ways) -> 0x100 evicted, 0x200 and 0x300 hit.
REQ-040 ghr=0x0F, lookup_en with mispredict update in the same cycle (branch_ghr=0x03, actual=1) -> ghr=0x07 next cycle.
REQ-041 Taken update and lookup of the same PC in the same cycle -> lookup shows a miss (pc_i+4); the next cycle shows a hit.
